// File: rtl/mem_responder_pkg.sv
// Shared types and default sizing for the adding-machine memory responder.
package mem_responder_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 6;
    localparam int DEF_WAIT_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/mem_responder_array.sv
// Program/data store: one synchronous write port shared by the access and
// preload paths, one combinational read port, contents never reset.
module mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              acc_we_i,
    input  logic [ADDR_W-1:0] acc_adr_i,
    input  logic [DATA_W-1:0] acc_data_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_adr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic [ADDR_W-1:0] rd_adr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Access writes take priority; the responder never issues both at once.
    always_ff @(posedge clk_i) begin
        if (acc_we_i) begin
            mem_q[acc_adr_i] <= acc_data_i;
        end else if (ld_we_i) begin
            mem_q[ld_adr_i] <= ld_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_adr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves rd_mem/wr_mem strobes after WAIT_CYCLES
// wait states with a one-cycle mem_ready pulse, plus an idle-time preload port.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              mem_ready,
    output logic              busy,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_adr,
    input  logic [DATA_W-1:0] load_data,
    output logic              conflict,
    output logic              overrun,
    input  logic              clr_err
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] adr_q;
    op_e               op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_out_q;
    logic              mem_ready_q;
    logic              busy_q;
    logic              conflict_q;
    logic              overrun_q;

    logic              idle_s;
    logic              strobe_one_s;
    logic              conflict_set_s;
    logic              overrun_set_s;
    logic              load_fire_s;
    logic              acc_we_s;
    logic [ADDR_W-1:0] rd_adr_s;
    logic [DATA_W-1:0] rd_data_s;

    assign idle_s         = (state_q == IDLE);
    assign strobe_one_s   = rd_mem ^ wr_mem;
    assign conflict_set_s = idle_s & ((rd_mem & wr_mem) | (load_en & (rd_mem | wr_mem)));
    assign overrun_set_s  = ~idle_s & (rd_mem | wr_mem | load_en);
    assign load_fire_s    = idle_s & load_en & ~rd_mem & ~wr_mem;
    // The write lands on the edge leaving RESPOND, so a reset during RESPOND abandons it.
    assign acc_we_s       = (state_q == RESPOND) & (op_q == OP_WR);
    // With no wait states the read is captured straight from the live address.
    assign rd_adr_s       = idle_s ? adr : adr_q;

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i      (clk),
        .acc_we_i   (acc_we_s),
        .acc_adr_i  (adr_q),
        .acc_data_i (wdata_q),
        .ld_we_i    (load_fire_s),
        .ld_adr_i   (load_adr),
        .ld_data_i  (load_data),
        .rd_adr_i   (rd_adr_s),
        .rd_data_o  (rd_data_s)
    );

    // Access FSM with registered outputs; read data is captured on entry to RESPOND.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            adr_q       <= '0;
            op_q        <= OP_RD;
            wdata_q     <= '0;
            data_out_q  <= '0;
            mem_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            conflict_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mem_ready_q <= 1'b0;
            conflict_q  <= conflict_set_s | (conflict_q & ~clr_err);
            overrun_q   <= overrun_set_s | (overrun_q & ~clr_err);
            case (state_q)
                IDLE: begin
                    if (strobe_one_s) begin
                        adr_q   <= adr;
                        op_q    <= wr_mem ? OP_WR : OP_RD;
                        wdata_q <= data_in;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= RESPOND;
                            mem_ready_q <= 1'b1;
                            if (rd_mem) begin
                                data_out_q <= rd_data_s;
                            end
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESPOND;
                        mem_ready_q <= 1'b1;
                        if (op_q == OP_RD) begin
                            data_out_q <= rd_data_s;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign mem_ready = mem_ready_q;
    assign busy      = busy_q;
    assign conflict  = conflict_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances with WAIT_CYCLES 0..3, a
// transaction-level memory/flag model, directed scenarios then random traffic.
module tb_mem_responder;

    localparam int NK = 4;

    logic       clk;
    logic       reset;
    logic       rd_mem    [NK];
    logic       wr_mem    [NK];
    logic [5:0] adr       [NK];
    logic [7:0] data_in   [NK];
    logic [7:0] data_out  [NK];
    logic       mem_ready [NK];
    logic       busy      [NK];
    logic       load_en   [NK];
    logic [5:0] load_adr  [NK];
    logic [7:0] load_data [NK];
    logic       conflict  [NK];
    logic       overrun   [NK];
    logic       clr_err   [NK];

    logic [7:0] ref_mem  [NK][64];
    logic [7:0] exp_dout [NK];
    logic       exp_conf [NK];
    logic       exp_ovr  [NK];

    int checks;
    int failures;

    for (genvar g = 0; g < NK; g++) begin : g_dut
        mem_responder #(
            .DATA_W      (8),
            .ADDR_W      (6),
            .WAIT_CYCLES (g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .rd_mem    (rd_mem[g]),
            .wr_mem    (wr_mem[g]),
            .adr       (adr[g]),
            .data_in   (data_in[g]),
            .data_out  (data_out[g]),
            .mem_ready (mem_ready[g]),
            .busy      (busy[g]),
            .load_en   (load_en[g]),
            .load_adr  (load_adr[g]),
            .load_data (load_data[g]),
            .conflict  (conflict[g]),
            .overrun   (overrun[g]),
            .clr_err   (clr_err[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input int k);
        chk($sformatf("conflict[%0d]", k), 32'(conflict[k]), 32'(exp_conf[k]));
        chk($sformatf("overrun[%0d]", k), 32'(overrun[k]), 32'(exp_ovr[k]));
    endtask

    task automatic load1(input int k, input logic [5:0] a, input logic [7:0] d);
        load_en[k] = 1'b1; load_adr[k] = a; load_data[k] = d;
        step();
        load_en[k] = 1'b0;
        ref_mem[k][a] = d;
        chk($sformatf("load_ready[%0d]", k), 32'(mem_ready[k]), 32'd0);
        chk($sformatf("load_busy[%0d]", k), 32'(busy[k]), 32'd0);
    endtask

    // One read/write on instance k (latency k); optional overrun injections at
    // busy-cycle index inj_rd / inj_ld and an optional colliding preload.
    task automatic access(input int k, input bit is_wr, input logic [5:0] a, input logic [7:0] d,
                          input int inj_rd, input int inj_ld, input bit col_ld);
        logic [7:0] old_dout;
        logic [7:0] new_dout;
        old_dout = exp_dout[k];
        new_dout = is_wr ? old_dout : ref_mem[k][a];
        rd_mem[k] = !is_wr; wr_mem[k] = is_wr; adr[k] = a; data_in[k] = d;
        if (col_ld) begin
            load_en[k] = 1'b1; load_adr[k] = a - 6'd1; load_data[k] = ~d;
            exp_conf[k] = 1'b1;
        end
        step();
        rd_mem[k] = 1'b0; wr_mem[k] = 1'b0; load_en[k] = 1'b0;
        for (int i = 0; i <= k; i++) begin
            if (i == inj_rd) begin
                rd_mem[k] = 1'b1; adr[k] = 6'($urandom); exp_ovr[k] = 1'b1;
            end
            if (i == inj_ld) begin
                load_en[k] = 1'b1; load_adr[k] = a; load_data[k] = ~ref_mem[k][a]; exp_ovr[k] = 1'b1;
            end
            chk($sformatf("busy[%0d]@%0d", k, i), 32'(busy[k]), 32'd1);
            chk($sformatf("ready[%0d]@%0d", k, i), 32'(mem_ready[k]), 32'(i == k));
            chk($sformatf("dout[%0d]@%0d", k, i), 32'(data_out[k]), 32'((i == k) ? new_dout : old_dout));
            step();
            rd_mem[k] = 1'b0; load_en[k] = 1'b0;
        end
        if (is_wr) ref_mem[k][a] = d;
        exp_dout[k] = new_dout;
        chk($sformatf("idle_busy[%0d]", k), 32'(busy[k]), 32'd0);
        chk($sformatf("idle_ready[%0d]", k), 32'(mem_ready[k]), 32'd0);
        chk($sformatf("hold_dout[%0d]", k), 32'(data_out[k]), 32'(exp_dout[k]));
        chk_flags(k);
    endtask

    task automatic clear_err(input int k);
        clr_err[k] = 1'b1;
        step();
        clr_err[k] = 1'b0;
        exp_conf[k] = 1'b0; exp_ovr[k] = 1'b0;
        chk_flags(k);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        for (int k = 0; k < NK; k++) begin
            rd_mem[k] = 1'b0; wr_mem[k] = 1'b0; adr[k] = 6'd0; data_in[k] = 8'd0;
            load_en[k] = 1'b0; load_adr[k] = 6'd0; load_data[k] = 8'd0; clr_err[k] = 1'b0;
            exp_dout[k] = 8'd0; exp_conf[k] = 1'b0; exp_ovr[k] = 1'b0;
        end
        step();
        step();
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("rst_dout[%0d]", k), 32'(data_out[k]), 32'd0);
            chk($sformatf("rst_ready[%0d]", k), 32'(mem_ready[k]), 32'd0);
            chk($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'd0);
            chk_flags(k);
        end
        reset = 1'b1;
        step();

        // Preload every word of every instance in parallel.
        for (int a = 0; a < 64; a++) begin
            for (int k = 0; k < NK; k++) begin
                load_en[k] = 1'b1; load_adr[k] = 6'(a); load_data[k] = 8'($urandom);
                ref_mem[k][a] = load_data[k];
            end
            step();
        end
        for (int k = 0; k < NK; k++) load_en[k] = 1'b0;

        // Preload then read with one wait state.
        load1(1, 6'h07, 8'h5A);
        access(1, 1'b0, 6'h07, 8'h00, -1, -1, 1'b0);
        chk("preload_read", 32'(data_out[1]), 32'h5A);

        // Zero-wait write to the top address, read back immediately.
        access(0, 1'b1, 6'h3F, 8'hC3, -1, -1, 1'b0);
        access(0, 1'b0, 6'h3F, 8'h00, -1, -1, 1'b0);
        chk("wr_rd_3f", 32'(data_out[0]), 32'hC3);

        // Simultaneous rd/wr: no access, conflict; set wins over clr_err.
        rd_mem[1] = 1'b1; wr_mem[1] = 1'b1; adr[1] = 6'h01; data_in[1] = ~ref_mem[1][1];
        step();
        rd_mem[1] = 1'b0; wr_mem[1] = 1'b0;
        exp_conf[1] = 1'b1;
        chk("conf_ready", 32'(mem_ready[1]), 32'd0);
        chk("conf_busy", 32'(busy[1]), 32'd0);
        chk_flags(1);
        access(1, 1'b0, 6'h01, 8'h00, -1, -1, 1'b0);
        rd_mem[1] = 1'b1; wr_mem[1] = 1'b1; clr_err[1] = 1'b1;
        step();
        rd_mem[1] = 1'b0; wr_mem[1] = 1'b0; clr_err[1] = 1'b0;
        chk_flags(1);
        clear_err(1);

        // Overrun: second strobe in WAIT, preload in RESPOND; both ignored.
        access(2, 1'b0, 6'h02, 8'h00, 0, 2, 1'b0);
        access(2, 1'b0, 6'h02, 8'h00, -1, -1, 1'b0);
        clear_err(2);

        // Preload colliding with a write: write served, load dropped.
        access(1, 1'b1, 6'h05, 8'h96, -1, -1, 1'b1);
        access(1, 1'b0, 6'h04, 8'h00, -1, -1, 1'b0);
        access(1, 1'b0, 6'h05, 8'h00, -1, -1, 1'b0);
        clear_err(1);

        // Reset mid-access on the three-wait instance.
        rd_mem[3] = 1'b1; adr[3] = 6'h10;
        step();
        rd_mem[3] = 1'b0;
        step();
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < NK; k++) begin
            exp_dout[k] = 8'd0; exp_conf[k] = 1'b0; exp_ovr[k] = 1'b0;
            chk($sformatf("midrst_dout[%0d]", k), 32'(data_out[k]), 32'd0);
            chk($sformatf("midrst_ready[%0d]", k), 32'(mem_ready[k]), 32'd0);
            chk($sformatf("midrst_busy[%0d]", k), 32'(busy[k]), 32'd0);
            chk_flags(k);
        end
        #2 reset = 1'b1;
        step();
        access(3, 1'b0, 6'h10, 8'h00, -1, -1, 1'b0);
        access(3, 1'b0, 6'h11, 8'h00, -1, -1, 1'b0);

        // Random traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            int k;
            int op;
            logic [5:0] a;
            logic [7:0] d;
            k  = int'($urandom_range(0, NK - 1));
            op = int'($urandom_range(0, 11));
            a  = 6'($urandom);
            d  = 8'($urandom);
            if (op < 2) begin
                load1(k, a, d);
            end else if (op < 6) begin
                access(k, 1'b0, a, d, -1, -1, 1'b0);
            end else if (op < 9) begin
                access(k, 1'b1, a, d, -1, -1, 1'b0);
            end else if (op == 9) begin
                access(k, 1'b1, a, d, -1, -1, 1'b1);
                clear_err(k);
            end else begin
                access(k, op[0], a, d, int'($urandom_range(0, k)), int'($urandom_range(0, k)), 1'b0);
                clear_err(k);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
